// File: rtl/conv_seq_pkg.sv
// Shared types and constants for the convolution sequencer: FSM states,
// offset generator mode encodings and per-phase word counts.
package conv_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILTER,
    ST_LINE,
    ST_MAC,
    ST_STORE,
    ST_FINISH
  } state_t;

  localparam logic [1:0] MODE_FILTER = 2'b00;
  localparam logic [1:0] MODE_STORE  = 2'b01;
  localparam logic [1:0] MODE_LINE   = 2'b10;

  localparam int FILTER_WORDS = 4;
  localparam int LINE_WORDS   = 4;

  // States that issue memory accesses and therefore can stall on mem_ready.
  function automatic logic is_mem_state(input state_t s);
    return (s == ST_FILTER) || (s == ST_LINE) || (s == ST_STORE);
  endfunction

endpackage

// File: rtl/conv_seq_perf.sv
// Saturating stall counter: +1 per stalled memory cycle, cleared on run start.
// One-cycle update latency; no backpressure (pure observer).
module conv_seq_perf #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] stall_cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (clr) begin
      stall_cnt <= '0;
    end else if (inc && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/conv_sequencer.sv
// Convolution control FSM: filter load, then per output line read / MAC / store. Optional CONV_SEQ_PERF_EN adds stall_cnt.
// Outputs decode from registered state plus mem_ready; mem_ready=0 freezes FILTER/LINE/STORE with no access issued.
module conv_sequencer
  import conv_seq_pkg::*;
#(
  parameter int NUM_OUTPUTS = 16,
  parameter int MAC_CYCLES  = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mem_ready,
  input  logic             og_done,
  output logic             og_active,
  output logic [1:0]       og_mode,
  output logic             og_clr,
  output logic             mac_en,
  output logic             mac_clr,
  output logic             wr_en,
  output logic             busy,
  output logic             finish,
`ifdef CONV_SEQ_PERF_EN
  output logic [CNT_W-1:0] stall_cnt,
`endif
  output logic [CNT_W-1:0] out_idx
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_OUTPUTS - 1);
  localparam logic [CNT_W-1:0] LAST_MAC = CNT_W'(MAC_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] mac_cnt;
  logic             start_acc;
  logic             idx_inc;
  logic             mac_step;
  logic             mac_wrap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    og_active = 1'b0;
    og_mode   = MODE_FILTER;
    og_clr    = 1'b0;
    mac_en    = 1'b0;
    mac_clr   = 1'b0;
    wr_en     = 1'b0;
    busy      = 1'b0;
    finish    = 1'b0;
    start_acc = 1'b0;
    idx_inc   = 1'b0;
    mac_step  = 1'b0;
    mac_wrap  = 1'b0;
    case (state)
      ST_IDLE: begin
        // Holding the offset generator in clear makes every run start at offset 0.
        og_clr = 1'b1;
        if (start) begin
          start_acc = 1'b1;
          state_nxt = ST_FILTER;
        end
      end
      ST_FILTER: begin
        busy      = 1'b1;
        og_mode   = MODE_FILTER;
        og_active = mem_ready;
        if (mem_ready && og_done) state_nxt = ST_LINE;
      end
      ST_LINE: begin
        busy      = 1'b1;
        og_mode   = MODE_LINE;
        og_active = mem_ready;
        if (mem_ready && og_done) state_nxt = ST_MAC;
      end
      ST_MAC: begin
        // Mode stays LINE so the offset output is stable while the MAC consumes data.
        busy    = 1'b1;
        og_mode = MODE_LINE;
        mac_en  = 1'b1;
        mac_clr = (mac_cnt == '0);
        if (mac_cnt == LAST_MAC) begin
          mac_wrap  = 1'b1;
          state_nxt = ST_STORE;
        end else begin
          mac_step = 1'b1;
        end
      end
      ST_STORE: begin
        busy      = 1'b1;
        og_mode   = MODE_STORE;
        og_active = mem_ready;
        wr_en     = mem_ready;
        if (mem_ready) begin
          if (out_idx == LAST_IDX) begin
            state_nxt = ST_FINISH;
          end else begin
            idx_inc   = 1'b1;
            state_nxt = ST_LINE;
          end
        end
      end
      ST_FINISH: begin
        busy      = 1'b1;
        finish    = 1'b1;
        og_mode   = MODE_FILTER;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_idx <= '0;
      mac_cnt <= '0;
    end else begin
      if (start_acc) begin
        out_idx <= '0;
      end else if (idx_inc) begin
        out_idx <= out_idx + CNT_W'(1);
      end
      if (mac_wrap) begin
        mac_cnt <= '0;
      end else if (mac_step) begin
        mac_cnt <= mac_cnt + CNT_W'(1);
      end
    end
  end

`ifdef CONV_SEQ_PERF_EN
  conv_seq_perf #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk      (clk),
    .rst      (rst),
    .clr      (start_acc),
    .inc      (is_mem_state(state) && !mem_ready),
    .stall_cnt(stall_cnt)
  );
`endif

endmodule

// File: tb/tb_conv_sequencer.sv
// Bench for conv_sequencer: two instances (2 outputs x 4 MAC cycles, 1 x 1) with an offset generator model each.
// Expected per-cycle output vectors are queued with the stimulus and compared as the DUT runs.
module tb_conv_sequencer;
  import conv_seq_pkg::*;

  localparam int P_IDLE  = 0;
  localparam int P_FILT  = 1;
  localparam int P_LINE  = 2;
  localparam int P_MAC   = 3;
  localparam int P_STORE = 4;
  localparam int P_FIN   = 5;

  typedef struct packed {
    logic        act;
    logic [1:0]  mode;
    logic        clr;
    logic        mac_en;
    logic        mac_clr;
    logic        wr;
    logic        busy;
    logic        fin;
    logic [15:0] idx;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start_a, mr_a, done_a, act_a, clr_a, mac_en_a, mac_clr_a, wr_a, busy_a, fin_a;
  logic start_b, mr_b, done_b, act_b, clr_b, mac_en_b, mac_clr_b, wr_b, busy_b, fin_b;
  logic [1:0]  mode_a, mode_b;
  logic [15:0] idx_a, idx_b;
`ifdef CONV_SEQ_PERF_EN
  logic [15:0] stall_a, stall_b;
`endif

  conv_sequencer #(.NUM_OUTPUTS(2), .MAC_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start_a), .mem_ready(mr_a), .og_done(done_a),
    .og_active(act_a), .og_mode(mode_a), .og_clr(clr_a), .mac_en(mac_en_a),
    .mac_clr(mac_clr_a), .wr_en(wr_a), .busy(busy_a), .finish(fin_a),
`ifdef CONV_SEQ_PERF_EN
    .stall_cnt(stall_a),
`endif
    .out_idx(idx_a)
  );

  conv_sequencer #(.NUM_OUTPUTS(1), .MAC_CYCLES(1), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .mem_ready(mr_b), .og_done(done_b),
    .og_active(act_b), .og_mode(mode_b), .og_clr(clr_b), .mac_en(mac_en_b),
    .mac_clr(mac_clr_b), .wr_en(wr_b), .busy(busy_b), .finish(fin_b),
`ifdef CONV_SEQ_PERF_EN
    .stall_cnt(stall_b),
`endif
    .out_idx(idx_b)
  );

  // Offset generator model: 4-access counter in FILTER/LINE modes, cleared by og_clr.
  logic [1:0] ogc_a = 2'd0;
  logic [1:0] ogc_b = 2'd0;
  always @(posedge clk) begin
    if (clr_a) ogc_a <= 2'd0;
    else if (act_a && mode_a != MODE_STORE) ogc_a <= ogc_a + 2'd1;
    if (clr_b) ogc_b <= 2'd0;
    else if (act_b && mode_b != MODE_STORE) ogc_b <= ogc_b + 2'd1;
  end
  assign done_a = (ogc_a == 2'(FILTER_WORDS - 1)) && (mode_a != MODE_STORE);
  assign done_b = (ogc_b == 2'(FILTER_WORDS - 1)) && (mode_b != MODE_STORE);

  obs_t obs_a, obs_b;
  assign obs_a = {act_a, mode_a, clr_a, mac_en_a, mac_clr_a, wr_a, busy_a, fin_a, idx_a};
  assign obs_b = {act_b, mode_b, clr_b, mac_en_b, mac_clr_b, wr_b, busy_b, fin_b, idx_b};

  int total = 0;
  int bad = 0;
  int wr_seen, fin_seen, act_seen;

  logic q_mr[$];
  logic q_st[$];
  obs_t q_exp[$];
  int   plan_cyc;
  logic plan_hold;
  int   plan_pulse;

  function automatic obs_t ex(input int ph, input logic mr, input logic [15:0] idx, input logic first);
    obs_t o;
    o = '0;
    o.idx = idx;
    case (ph)
      P_IDLE:  o.clr = 1'b1;
      P_FILT:  begin o.act = mr; o.mode = MODE_FILTER; o.busy = 1'b1; end
      P_LINE:  begin o.act = mr; o.mode = MODE_LINE; o.busy = 1'b1; end
      P_MAC:   begin o.mode = MODE_LINE; o.mac_en = 1'b1; o.mac_clr = first; o.busy = 1'b1; end
      P_STORE: begin o.act = mr; o.wr = mr; o.mode = MODE_STORE; o.busy = 1'b1; end
      P_FIN:   begin o.fin = 1'b1; o.busy = 1'b1; o.mode = MODE_FILTER; end
      default: o = '0;
    endcase
    return o;
  endfunction

  task automatic push(input int ph, input logic mr, input logic [15:0] idx, input logic first);
    q_mr.push_back(mr);
    q_st.push_back((plan_cyc == 0) || plan_hold || (plan_cyc == plan_pulse));
    q_exp.push_back(ex(ph, mr, idx, first));
    plan_cyc++;
  endtask

  task automatic plan_run(input int n_out, input int mac_c, input logic [15:0] idx0, input int pulse_at,
                          input logic hold, input logic filt_alt, input int ls, input int ss,
                          input logic final_idle);
    plan_cyc = 0;
    plan_hold = hold;
    plan_pulse = pulse_at;
    push(P_IDLE, 1'b1, idx0, 1'b0);
    if (filt_alt) begin
      for (int k = 0; k < 2 * FILTER_WORDS; k++) push(P_FILT, logic'(k % 2), 16'd0, 1'b0);
    end else begin
      for (int k = 0; k < FILTER_WORDS; k++) push(P_FILT, 1'b1, 16'd0, 1'b0);
    end
    for (int o = 0; o < n_out; o++) begin
      if (o == 0) for (int s = 0; s < ls; s++) push(P_LINE, 1'b0, 16'(o), 1'b0);
      for (int k = 0; k < LINE_WORDS; k++) push(P_LINE, 1'b1, 16'(o), 1'b0);
      for (int k = 0; k < mac_c; k++) push(P_MAC, 1'b1, 16'(o), k == 0);
      if (o == 0) for (int s = 0; s < ss; s++) push(P_STORE, 1'b0, 16'(o), 1'b0);
      push(P_STORE, 1'b1, 16'(o), 1'b0);
    end
    push(P_FIN, 1'b1, 16'(n_out - 1), 1'b0);
    if (final_idle) begin
      plan_hold = 1'b0;
      plan_pulse = -1;
      push(P_IDLE, 1'b1, 16'(n_out - 1), 1'b0);
    end
  endtask

  task automatic run_plan(input int sel, input string name, input int limit);
    obs_t got, expv;
    int c;
    c = 0;
    wr_seen = 0; fin_seen = 0; act_seen = 0;
    while (q_exp.size() > 0 && c < limit) begin
      @(negedge clk);
      if (sel == 0) begin mr_a = q_mr.pop_front(); start_a = q_st.pop_front(); end
      else begin mr_b = q_mr.pop_front(); start_b = q_st.pop_front(); end
      #1;
      got = (sel == 0) ? obs_a : obs_b;
      expv = q_exp.pop_front();
      wr_seen += int'(got.wr);
      fin_seen += int'(got.fin);
      act_seen += int'(got.act);
      total++;
      if (got !== expv) begin
        bad++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, c, got, expv);
      end
      c++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0; mr_a = 1'b1; mr_b = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (obs_a !== ex(P_IDLE, 1'b1, 16'd0, 1'b0)) begin
      bad++; $display("FAIL reset_a: got %h expected %h", obs_a, ex(P_IDLE, 1'b1, 16'd0, 1'b0));
    end
    total++;
    if (obs_b !== ex(P_IDLE, 1'b1, 16'd0, 1'b0)) begin
      bad++; $display("FAIL reset_b: got %h expected %h", obs_b, ex(P_IDLE, 1'b1, 16'd0, 1'b0));
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_nominal();
    plan_run(2, 4, 16'd0, -1, 1'b0, 1'b0, 0, 0, 1'b1);
    run_plan(0, "nominal", 1000);
    total++;
    if (wr_seen !== 2) begin bad++; $display("FAIL nominal_wr_count: got %0d expected 2", wr_seen); end
    total++;
    if (fin_seen !== 1) begin bad++; $display("FAIL nominal_finish_count: got %0d expected 1", fin_seen); end
  endtask

  task automatic test_backpressure();
    plan_run(2, 4, 16'd1, -1, 1'b0, 1'b1, 0, 0, 1'b1);
    run_plan(0, "backpressure", 1000);
    total++;
    if (act_seen !== 14) begin bad++; $display("FAIL bp_access_count: got %0d expected 14", act_seen); end
  endtask

  task automatic test_start_ignored();
    plan_run(2, 4, 16'd1, 10, 1'b0, 1'b0, 0, 0, 1'b1);
    run_plan(0, "start_midrun", 1000);
    total++;
    if (fin_seen !== 1) begin bad++; $display("FAIL midrun_finish_count: got %0d expected 1", fin_seen); end
    plan_run(2, 4, 16'd1, -1, 1'b0, 1'b0, 0, 0, 1'b1);
    run_plan(0, "second_run", 1000);
  endtask

  task automatic test_back_to_back();
    plan_run(2, 4, 16'd1, -1, 1'b1, 1'b0, 0, 0, 1'b0);
    plan_run(2, 4, 16'd1, -1, 1'b0, 1'b0, 0, 0, 1'b1);
    run_plan(0, "back_to_back", 1000);
    total++;
    if (fin_seen !== 2) begin bad++; $display("FAIL b2b_finish_count: got %0d expected 2", fin_seen); end
  endtask

  task automatic test_reset_mid_run();
    plan_run(2, 4, 16'd1, -1, 1'b0, 1'b0, 0, 0, 1'b1);
    run_plan(0, "pre_reset", 11);
    q_mr.delete(); q_st.delete(); q_exp.delete();
    @(negedge clk);
    start_a = 1'b0;
    rst = 1'b0;
    #1;
    total++;
    if (obs_a !== ex(P_IDLE, 1'b1, 16'd0, 1'b0)) begin
      bad++; $display("FAIL reset_mid_mac: got %h expected %h", obs_a, ex(P_IDLE, 1'b1, 16'd0, 1'b0));
    end
    @(negedge clk);
    rst = 1'b1;
    plan_run(2, 4, 16'd0, -1, 1'b0, 1'b0, 0, 0, 1'b1);
    run_plan(0, "after_reset", 1000);
  endtask

  task automatic test_mac1();
    plan_run(1, 1, 16'd0, -1, 1'b0, 1'b0, 0, 0, 1'b1);
    run_plan(1, "mac1", 1000);
    total++;
    if (wr_seen !== 1) begin bad++; $display("FAIL mac1_wr_count: got %0d expected 1", wr_seen); end
  endtask

`ifdef CONV_SEQ_PERF_EN
  task automatic test_perf();
    plan_run(2, 4, 16'd1, -1, 1'b0, 1'b0, 3, 1, 1'b1);
    run_plan(0, "perf_stalls", 1000);
    total++;
    if (stall_a !== 16'd4) begin bad++; $display("FAIL stall_cnt_end: got %0d expected 4", stall_a); end
    plan_run(2, 4, 16'd1, -1, 1'b0, 1'b0, 0, 0, 1'b1);
    run_plan(0, "perf_restart", 2);
    total++;
    if (stall_a !== 16'd0) begin bad++; $display("FAIL stall_cnt_clear: got %0d expected 0", stall_a); end
    run_plan(0, "perf_restart_tail", 1000);
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_start_ignored();
    test_back_to_back();
`ifdef CONV_SEQ_PERF_EN
    test_perf();
`endif
    test_reset_mid_run();
    test_mac1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_sequencer.md
Name: conv_sequencer

Overview:
- Top-level control FSM for the convolution datapath. It sequences the offset generator through its three modes (reading filter, reading line, storing data) and gates a MAC unit.
- Loads the 4-word filter once per run. Then, for each of NUM_OUTPUTS outputs: reads a 4-word line, runs MAC_CYCLES of accumulation and stores one result word.
- Sits between the host start/finish handshake and the offset generator / memory / MAC.

Parameters:
- NUM_OUTPUTS, 16, number of output words per run (>=1).
- MAC_CYCLES, 4, accumulate cycles per output (>=1).
- CNT_W, 16, width of the output index and internal counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  run request; sampled in IDLE only.
- mem_ready  in  1  memory accepts an access this cycle.
- og_done  in  1  done flag from the offset generator; meaningful only while og_active=1.
- og_active  out  1  offset generator count enable (one memory access per cycle).
- og_mode  out  2  offset generator mode: 00 filter, 01 store, 10 line.
- og_clr  out  1  active-high clear to the offset generator's rst.
- mac_en  out  1  MAC accumulate enable.
- mac_clr  out  1  MAC accumulator clear.
- wr_en  out  1  result write strobe.
- busy  out  1  run in progress.
- finish  out  1  one-cycle end-of-run pulse.
- out_idx  out  CNT_W  index of the output currently being produced.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; out_idx=0; internal counters=0; og_active=mac_en=mac_clr=wr_en=busy=finish=0; og_mode=00; og_clr=1.
- Outputs are decoded from the registered state plus mem_ready. No other combinational input-to-output paths.
- States: IDLE, FILTER, LINE, MAC, STORE, FINISH.
- IDLE:
  - og_clr=1, busy=0.
  - start=1 -> FILTER; out_idx<=0.
- FILTER:
  - og_mode=00, og_active=mem_ready, busy=1.
  - When og_active & og_done -> LINE. This is the 4th accepted access.
- LINE:
  - og_mode=10, og_active=mem_ready.
  - When og_active & og_done -> MAC. og_done marks the 4th access of the line.
- MAC:
  - og_active=0, og_mode=10 (held so the offset output stays stable), mac_en=1.
  - mac_clr=1 on the first MAC cycle only.
  - Internal counter runs 0..MAC_CYCLES-1. At MAC_CYCLES-1 -> STORE. MAC_CYCLES=1 gives a single cycle with both mac_en and mac_clr high.
- STORE:
  - og_mode=01, og_active=mem_ready, wr_en=mem_ready.
  - On the accepted write: if out_idx==NUM_OUTPUTS-1 -> FINISH, else out_idx<=out_idx+1 and -> LINE.
- FINISH: finish=1, busy=1, og_mode=00; next cycle -> IDLE.
- Stalls: mem_ready=0 in FILTER, LINE or STORE holds the state with og_active=0, so no offset increments.
- start while not in IDLE is ignored. start held high continuously re-launches a run immediately after each return to IDLE.
- Because og_clr is high in IDLE, the offset generator counters restart from 0 on every run.
- Reset mid-run aborts immediately; no partial-run state is retained.

Optional Feature:
- CONV_SEQ_PERF_EN defined:
  - Adds output stall_cnt [CNT_W-1:0].
  - Increments each cycle in FILTER, LINE or STORE with mem_ready=0; saturates at all-ones.
  - Cleared to 0 on reset and when start is accepted.
  - Holds its value after FINISH.
- Undefined: no stall_cnt port and no counter logic.

Decomposition:
- Package conv_seq_pkg holds:
  - the state enum (IDLE..FINISH, 3-bit);
  - offset generator mode constants MODE_FILTER=2'b00, MODE_STORE=2'b01, MODE_LINE=2'b10;
  - FILTER_WORDS=4 and LINE_WORDS=4.
- One sub-module is natural: conv_seq_perf (the saturating stall counter), instantiated only under CONV_SEQ_PERF_EN.
- FSM and counters stay in conv_sequencer.

Test Plan:
- Nominal run (NUM_OUTPUTS=2, MAC_CYCLES=4, mem_ready=1, start at cycle 0) -> FILTER 1-4, LINE 5-8, MAC 9-12, STORE 13, LINE 14-17, MAC 18-21, STORE 22; finish pulse at cycle 23; exactly 2 wr_en pulses; out_idx 0 then 1.
- Backpressure (mem_ready alternating 1/0 from cycle 1) -> FILTER lasts 8 cycles; exactly 4 og_active cycles; no og_active while mem_ready=0.
- start pulsed at cycle 10 of a run -> ignored, single finish. A second start after IDLE -> identical cycle timing to the first run, confirming og_clr reset of the offset generator.
- rst=0 asserted during MAC -> outputs take reset values within the same cycle (og_clr=1, busy=0); after release, a new start runs cleanly.
- MAC_CYCLES=1, NUM_OUTPUTS=1 -> a single MAC cycle with mac_en=mac_clr=1; one store; finish.
- CONV_SEQ_PERF_EN, with mem_ready=0 for 3 cycles in LINE and 1 cycle in STORE -> stall_cnt=4 at finish; cleared to 0 on the next accepted start.
